// File: rtl/fir_mac_seq.sv
`default_nettype none
//==============================================================================
// Module : fir_mac_seq
// Desc   : Sequential single-multiplier FIR MAC. Snapshots the delay line on
//          start, accumulates one tap per cycle, rounds/shifts/saturates.
// Rev    : 1.0  initial release
//==============================================================================
module fir_mac_seq #(
  parameter int NUM_TAPS    = 10,
  parameter int DATA_WIDTH  = 16,
  parameter int COEFF_WIDTH = 16,
  parameter int FRAC_BITS   = 15,
  parameter int ROUND_EN    = 1,
  localparam int ADDR_WIDTH = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1
) (
  input  logic                               iClk_12M,
  input  logic                               iRsn,
  input  logic                               iStart,
  input  logic [NUM_TAPS*DATA_WIDTH-1:0]     iDelay,
  input  logic signed [COEFF_WIDTH-1:0]      iCoeff,
  output logic [ADDR_WIDTH-1:0]              oCoeffAddr,
  output logic                               oBusy,
  output logic                               oValid,
  output logic signed [DATA_WIDTH-1:0]       oMac,
  output logic                               oSat,
  output logic                               oDrop
);

  localparam int PROD_WIDTH = DATA_WIDTH + COEFF_WIDTH;
  localparam int ACC_WIDTH  = PROD_WIDTH + $clog2(NUM_TAPS);
  localparam int EXT_WIDTH  = ACC_WIDTH + 1;

  localparam logic [ADDR_WIDTH-1:0]       c_last = ADDR_WIDTH'(NUM_TAPS - 1);
  localparam logic signed [EXT_WIDTH-1:0] c_half = EXT_WIDTH'(1) << (FRAC_BITS - 1);
  localparam logic signed [EXT_WIDTH-1:0] c_max  =
    {{(EXT_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [EXT_WIDTH-1:0] c_min  =
    {{(EXT_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                         r_state;
  state_t                         w_state_nxt;
  logic                           w_busy;
  logic signed [DATA_WIDTH-1:0]   w_taps [NUM_TAPS];
  logic signed [DATA_WIDTH-1:0]   r_snap [NUM_TAPS];
  logic signed [ACC_WIDTH-1:0]    r_acc;
  logic [ADDR_WIDTH-1:0]          r_addr;
  logic signed [PROD_WIDTH-1:0]   w_prod;
  logic signed [ACC_WIDTH-1:0]    w_prod_ext;
  logic signed [EXT_WIDTH-1:0]    w_rnd;
  logic signed [EXT_WIDTH-1:0]    w_shift;
  logic signed [DATA_WIDTH-1:0]   w_mac;
  logic                           w_sat;
  logic signed [DATA_WIDTH-1:0]   r_mac;
  logic                           r_sat;
  logic                           r_valid;
  logic                           r_drop;

  generate
    for (genvar gi = 0; gi < NUM_TAPS; gi++) begin : g_tap
      assign w_taps[gi] = iDelay[DATA_WIDTH*(gi+1)-1 : DATA_WIDTH*gi];
    end
  endgenerate

  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    case (r_state)
      S_IDLE: if (iStart) w_state_nxt = S_RUN;
      S_RUN: begin
        w_busy = 1'b1;
        if (r_addr == c_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_busy      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Full-precision product, sign-extended into the accumulator width
  assign w_prod     = PROD_WIDTH'(r_snap[r_addr]) * PROD_WIDTH'(iCoeff);
  assign w_prod_ext = ACC_WIDTH'(w_prod);

  always_comb begin
    w_rnd   = EXT_WIDTH'(r_acc) + ((ROUND_EN != 0) ? c_half : '0);
    w_shift = w_rnd >>> FRAC_BITS;
    w_mac   = w_shift[DATA_WIDTH-1:0];
    w_sat   = 1'b0;
    if (w_shift > c_max) begin
      w_mac = c_max[DATA_WIDTH-1:0];
      w_sat = 1'b1;
    end else if (w_shift < c_min) begin
      w_mac = c_min[DATA_WIDTH-1:0];
      w_sat = 1'b1;
    end
  end

  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      for (int i = 0; i < NUM_TAPS; i++) r_snap[i] <= '0;
      r_acc   <= '0;
      r_addr  <= '0;
      r_mac   <= '0;
      r_sat   <= 1'b0;
      r_valid <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_drop  <= iStart && w_busy;
      case (r_state)
        S_IDLE: begin
          if (iStart) begin
            for (int i = 0; i < NUM_TAPS; i++) r_snap[i] <= w_taps[i];
            r_acc  <= '0;
            r_addr <= '0;
          end
        end
        S_RUN: begin
          r_acc  <= r_acc + w_prod_ext;
          r_addr <= (r_addr == c_last) ? '0 : r_addr + ADDR_WIDTH'(1);
        end
        S_DONE: begin
          r_mac   <= w_mac;
          r_sat   <= w_sat;
          r_valid <= 1'b1;
          r_addr  <= '0;
        end
        default: r_addr <= '0;
      endcase
    end
  end

  assign oCoeffAddr = r_addr;
  assign oBusy      = w_busy;
  assign oValid     = r_valid;
  assign oMac       = r_mac;
  assign oSat       = r_sat;
  assign oDrop      = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_fir_mac_seq.sv
`default_nettype none
//==============================================================================
// Module : tb_fir_mac_seq
// Desc   : Self-checking bench for fir_mac_seq (directed table + random model).
// Rev    : 1.0  initial release
//==============================================================================
module tb_fir_mac_seq;
  localparam int NT       = 10;
  localparam int DW       = 16;
  localparam int CW       = 16;
  localparam int FRAC     = 15;
  localparam int ROUND_EN = 1;

  typedef int tapv_t [NT];
  typedef struct {
    string name;
    int    tap0;
    int    tap_rest;
    int    c0;
    int    c_rest;
    int    exp_mac;
    bit    exp_sat;
  } vec_t;

  logic                    clk;
  logic                    rsn;
  logic                    start;
  logic [NT*DW-1:0]        delay;
  logic signed [CW-1:0]    coeff_w;
  logic [3:0]              addr;
  logic                    busy;
  logic                    valid;
  logic signed [DW-1:0]    mac;
  logic                    sat;
  logic                    drop;

  logic signed [CW-1:0]    coeff_tbl [NT];
  logic [NT*DW-1:0]        hist [50];
  vec_t                    vecs [8];

  int n_pass  = 0;
  int n_total = 0;

  fir_mac_seq #(
    .NUM_TAPS(NT), .DATA_WIDTH(DW), .COEFF_WIDTH(CW),
    .FRAC_BITS(FRAC), .ROUND_EN(ROUND_EN)
  ) dut (
    .iClk_12M(clk), .iRsn(rsn), .iStart(start), .iDelay(delay),
    .iCoeff(coeff_w), .oCoeffAddr(addr), .oBusy(busy), .oValid(valid),
    .oMac(mac), .oSat(sat), .oDrop(drop)
  );

  assign coeff_w = coeff_tbl[addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference: plain integer dot product, round-half-up, floor shift, clamp
  function automatic void model(input tapv_t t, input tapv_t c, output int m, output bit s);
    longint acc;
    acc = 0;
    for (int i = 0; i < NT; i++) acc += longint'(t[i]) * longint'(c[i]);
    if (ROUND_EN != 0) acc += longint'(1) <<< (FRAC - 1);
    acc = acc >>> FRAC;
    s = 1'b0;
    if (acc > 32767)       begin acc = 32767;  s = 1'b1; end
    else if (acc < -32768) begin acc = -32768; s = 1'b1; end
    m = int'(acc);
  endfunction

  function automatic logic [NT*DW-1:0] pack(input tapv_t t);
    logic [NT*DW-1:0] p;
    int v;
    for (int i = 0; i < NT; i++) begin
      v = t[i];
      p[i*DW +: DW] = v[DW-1:0];
    end
    return p;
  endfunction

  function automatic void unpack(input logic [NT*DW-1:0] p, output tapv_t t);
    logic signed [DW-1:0] v;
    for (int i = 0; i < NT; i++) begin
      v = p[i*DW +: DW];
      t[i] = int'(v);
    end
  endfunction

  function automatic int rand16(input int sh);
    logic signed [15:0] v;
    v = 16'($urandom);
    return int'(v) >>> sh;
  endfunction

  function automatic logic [NT*DW-1:0] rand_delay();
    logic [NT*DW-1:0] p;
    for (int i = 0; i < NT; i++) p[i*DW +: DW] = 16'($urandom);
    return p;
  endfunction

  task automatic load_coeffs(input tapv_t c);
    int v;
    for (int i = 0; i < NT; i++) begin
      v = c[i];
      coeff_tbl[i] = v[CW-1:0];
    end
  endtask

  // One sample: accept, optionally scramble iDelay during RUN, wait for oValid
  task automatic run_sample(input tapv_t t, input tapv_t c, input bit scramble,
                            output int m, output bit s, output int lat, output bit b);
    @(negedge clk);
    delay = pack(t);
    load_coeffs(c);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    b = busy;
    lat = 0; m = 0; s = 1'b0;
    while (lat < 30) begin
      @(posedge clk); #1;
      lat++;
      if (scramble) delay = rand_delay();
      if (valid) begin
        m = int'(mac);
        s = sat;
        break;
      end
    end
  endtask

  tapv_t t, c;
  int    m, em, lat, w;
  bit    s, es, b;
  int    drop_err, drop_cnt, vcnt, valid_err;
  bit    saw_valid;

  initial begin
    rsn = 1'b0; start = 1'b0; delay = '0;
    for (int i = 0; i < NT; i++) coeff_tbl[i] = '0;

    vecs[0] = '{"impulse",    16384,  0,      16384, 1000, 8192,   1'b0};
    vecs[1] = '{"sat_pos",    32767,  32767,  32767, 32767, 32767, 1'b1};
    vecs[2] = '{"sat_neg",   -32768, -32768,  32767, 32767, -32768, 1'b1};
    vecs[3] = '{"tie_pos",    1,      0,      16384, 500,  1,      1'b0};
    vecs[4] = '{"tie_neg",   -1,      0,      16384, 500,  0,      1'b0};
    vecs[5] = '{"tie_3",      3,      0,      16384, 77,   2,      1'b0};
    vecs[6] = '{"tie_m3",    -3,      0,      16384, 77,   -1,     1'b0};
    vecs[7] = '{"flat_neg",  -1000,  -1000,   3277,  3277, -1000,  1'b0};

    #1;
    check("rst_addr",  addr,  0);
    check("rst_busy",  busy,  0);
    check("rst_valid", valid, 0);
    check("rst_mac",   mac,   0);
    check("rst_sat",   sat,   0);
    check("rst_drop",  drop,  0);
    repeat (3) @(negedge clk);
    rsn = 1'b1;

    foreach (vecs[k]) begin
      for (int i = 0; i < NT; i++) begin
        t[i] = (i == 0) ? vecs[k].tap0 : vecs[k].tap_rest;
        c[i] = (i == 0) ? vecs[k].c0   : vecs[k].c_rest;
      end
      run_sample(t, c, 1'b0, m, s, lat, b);
      check({vecs[k].name, "_mac"},     m,   vecs[k].exp_mac);
      check({vecs[k].name, "_sat"},     s,   vecs[k].exp_sat);
      check({vecs[k].name, "_latency"}, lat, 11);
      check({vecs[k].name, "_busy"},    b,   1);
    end
    check("idle_addr", addr, 0);
    check("idle_busy", busy, 0);

    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < NT; i++) begin
        t[i] = rand16(n % 5);
        c[i] = rand16(n % 4);
      end
      model(t, c, em, es);
      run_sample(t, c, n[0], m, s, lat, b);
      check($sformatf("rand%0d_mac", n), m, em);
      check($sformatf("rand%0d_sat", n), s, es);
    end

    // iStart held high for 40 edges with iDelay changing every cycle
    for (int i = 0; i < NT; i++) c[i] = rand16(2);
    load_coeffs(c);
    drop_err = 0; drop_cnt = 0; vcnt = 0; valid_err = 0;
    @(negedge clk);
    for (int k = 0; k < 50; k++) begin
      start   = (k < 40);
      hist[k] = rand_delay();
      delay   = hist[k];
      @(posedge clk); #1;
      if (drop !== ((k < 40) && (k % 12 != 0))) drop_err++;
      if (drop) drop_cnt++;
      if (valid) begin
        vcnt++;
        if (k % 12 == 11) begin
          unpack(hist[k-11], t);
          model(t, c, em, es);
          check($sformatf("b2b_mac_edge%0d", k), mac, em);
          check($sformatf("b2b_sat_edge%0d", k), sat, es);
        end else valid_err++;
      end else if (k % 12 == 11) valid_err++;
      @(negedge clk);
    end
    check("b2b_drop_pattern_errors", drop_err, 0);
    check("b2b_drop_count", drop_cnt, 36);
    check("b2b_valid_count", vcnt, 4);
    check("b2b_valid_timing_errors", valid_err, 0);

    // Reset in the middle of a run
    for (int i = 0; i < NT; i++) begin t[i] = (i == 0) ? 16384 : 0; c[i] = 16384; end
    run_sample(t, c, 1'b0, m, s, lat, b);
    for (int i = 0; i < NT; i++) begin t[i] = rand16(3); c[i] = rand16(3); end
    @(negedge clk);
    delay = pack(t); load_coeffs(c); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    w = 0;
    while (addr != 4'd5 && w < 20) begin @(posedge clk); #1; w++; end
    check("rst_mid_reached_addr5", addr, 5);
    #2 rsn = 1'b0;
    #1;
    check("rst_mid_addr",  addr,  0);
    check("rst_mid_busy",  busy,  0);
    check("rst_mid_valid", valid, 0);
    check("rst_mid_mac",   mac,   0);
    check("rst_mid_sat",   sat,   0);
    check("rst_mid_drop",  drop,  0);
    saw_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; if (valid) saw_valid = 1'b1; end
    @(negedge clk);
    rsn = 1'b1;
    repeat (15) begin @(posedge clk); #1; if (valid) saw_valid = 1'b1; end
    check("rst_mid_no_valid", saw_valid, 0);

    for (int i = 0; i < NT; i++) begin t[i] = rand16(2); c[i] = rand16(2); end
    model(t, c, em, es);
    run_sample(t, c, 1'b1, m, s, lat, b);
    check("post_rst_mac",     m,   em);
    check("post_rst_sat",     s,   es);
    check("post_rst_latency", lat, 11);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fir_mac_seq.md
FIR_MAC_SEQ -- requirements
Module: fir_mac_seq

Interface
REQ-001 Parameter NUM_TAPS, default 10, number of taps in one MAC sequence; legal range 2..64.
REQ-002 Parameter DATA_WIDTH, default 16, signed sample and result width.
REQ-003 Parameter COEFF_WIDTH, default 16, signed coefficient width.
REQ-004 Parameter FRAC_BITS, default 15, coefficient fractional bits removed at output; legal range 1..COEFF_WIDTH-1.
REQ-005 Parameter ROUND_EN, default 1; 1 = round-half-up, 0 = truncate (floor).
REQ-006 iClk_12M  input  1  sole clock; all state changes on rising edge.
REQ-007 iRsn  input  1  reset, asynchronous assert, active-low.
REQ-008 iStart  input  1  request one output sample; sampled only in IDLE.
REQ-009 iDelay  input  NUM_TAPS*DATA_WIDTH  packed signed delay-line taps; tap i = bits [DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i].
REQ-010 iCoeff  input  COEFF_WIDTH  signed coefficient for oCoeffAddr, valid combinationally in the same cycle.
REQ-011 oCoeffAddr  output  max(1,clog2(NUM_TAPS))  tap index currently being multiplied.
REQ-012 oBusy  output  1  high in RUN and DONE states.
REQ-013 oValid  output  1  one-cycle pulse when oMac/oSat update.
REQ-014 oMac  output  DATA_WIDTH  signed filter output, held until next oValid.
REQ-015 oSat  output  1  result was clamped; updated with oMac.
REQ-016 oDrop  output  1  one-cycle pulse when iStart arrives while oBusy.

Function
REQ-017 FSM states IDLE, RUN, DONE; IDLE->RUN on iStart, RUN->DONE after tap NUM_TAPS-1, DONE->IDLE unconditionally.
REQ-018 On the edge that accepts iStart, all NUM_TAPS taps of iDelay SHALL be captured into an internal snapshot, accumulator cleared, oCoeffAddr set to 0.
REQ-019 iDelay changes after acceptance SHALL NOT affect the current result.
REQ-020 In RUN, each edge SHALL add snapshot[oCoeffAddr]*iCoeff to the accumulator and increment oCoeffAddr; exactly NUM_TAPS products per sample, taps in ascending order.
REQ-021 oCoeffAddr SHALL hold 0 in IDLE and DONE.
REQ-022 Product width DATA_WIDTH+COEFF_WIDTH; accumulator width DATA_WIDTH+COEFF_WIDTH+clog2(NUM_TAPS), full precision, no internal overflow.
REQ-023 On the DONE edge: if ROUND_EN, add 2^(FRAC_BITS-1) to the accumulator; then arithmetic shift right by FRAC_BITS.
REQ-024 Shifted value outside [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1] SHALL clamp to the nearer bound with oSat=1; otherwise oSat=0.
REQ-025 Latency: oValid high in the cycle after the (NUM_TAPS+1)th rising edge following the accepting edge; iStart in that same cycle SHALL be accepted (back-to-back period NUM_TAPS+2 cycles).
REQ-026 iStart while oBusy SHALL be ignored, pulse oDrop for one cycle, and not disturb the running sample.
REQ-027 iStart held high continuously SHALL start a new sample on each IDLE cycle only.

Reset
REQ-028 iRsn low SHALL immediately force IDLE, clear snapshot and accumulator, and drive oCoeffAddr=0, oBusy=0, oValid=0, oMac=0, oSat=0, oDrop=0.
REQ-029 Reset asserted mid-RUN SHALL abort the sample with no oValid; the first iStart after release starts a clean sample.

Verification (defaults NUM_TAPS=10, DATA 16, COEFF 16, FRAC 15)
REQ-030 Impulse: tap0=16384, others 0, coeff[0]=16384 -> oMac=8192, oSat=0, oValid 11 edges after accept.
REQ-031 Saturation: all taps 32767, all coeffs 32767 -> oMac=32767, oSat=1; all taps -32768, coeffs 32767 -> oMac=-32768, oSat=1.
REQ-032 Rounding tie: tap0=1, coeff0=16384 -> oMac=1 (ROUND_EN=1) / 0 (ROUND_EN=0); tap0=-1 -> 0 / -1.
REQ-033 Back-to-back: iStart held high 40 cycles -> oValid every 12 cycles, oDrop pulses each busy cycle, results match golden model.
REQ-034 Reset at oCoeffAddr=5 -> all outputs 0 asynchronously, no oValid; next sample correct.
REQ-035 Snapshot: iDelay randomised every cycle during RUN -> oMac equals result of taps captured at accept.
